// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: turns the raw device-clocked serial stream into the
// 11-bit toggle-strobed key event word {toggle, pressed, extended, code}.
// Optional build macro PS2_REPEAT_FILTER_EN suppresses typematic auto-repeat
// by dropping a make event identical to the last one emitted.
module ps2_key_rx #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 49152
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk_in,
   input  logic        ps2_data_in,
   output logic [10:0] ps2_key,
   output logic        frame_err
);

   localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   logic              clk_meta;
   logic              clk_sync;
   logic              data_meta;
   logic              data_sync;
   logic              clk_filt;
   logic [FILT_W-1:0] filt_cnt;
   logic              fall_stb;

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        bit_cnt;
   logic [7:0]        shift_reg;
   logic              parity_bit;
   logic              parity_ok;
   logic [TO_W-1:0]   to_cnt;
   logic              stop_good;
   logic              stop_bad;
   logic              timeout_hit;

   logic              byte_valid;
   logic [7:0]        byte_reg;
   logic              ext_flag;
   logic              brk_flag;
   logic [2:0]        skip_cnt;
   logic              is_ignored;
   logic              emit_ok;

`ifdef PS2_REPEAT_FILTER_EN
   logic              rep_valid;
   logic [8:0]        rep_key;
   logic              rep_match;
`endif

   // Two-flop synchronisers for the asynchronous PS/2 pins.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         clk_meta  <= 1'b1;
         clk_sync  <= 1'b1;
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         clk_meta  <= ps2_clk_in;
         clk_sync  <= clk_meta;
         data_meta <= ps2_data_in;
         data_sync <= data_meta;
      end
   end

   // Glitch filter: the clock level flips only after a full run of differing samples; a flip to 0 yields the fall strobe.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         clk_filt <= 1'b1;
         filt_cnt <= '0;
         fall_stb <= 1'b0;
      end else begin
         fall_stb <= 1'b0;
         if (clk_sync == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILT_LAST) begin
            clk_filt <= clk_sync;
            filt_cnt <= '0;
            fall_stb <= ~clk_sync;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   // Frame state register.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Frame sequencing: falls advance the frame, a stalled clock mid-frame abandons it.
   always_comb begin
      state_nxt   = state;
      stop_good   = 1'b0;
      stop_bad    = 1'b0;
      timeout_hit = 1'b0;
      parity_ok   = ^{shift_reg, parity_bit};
      if (fall_stb) begin
         case (state)
            ST_IDLE: begin
               if (!data_sync) begin
                  state_nxt = ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_cnt == 3'd7) begin
                  state_nxt = ST_PARITY;
               end
            end
            ST_PARITY: begin
               state_nxt = ST_STOP;
            end
            ST_STOP: begin
               state_nxt = ST_IDLE;
               if (data_sync && parity_ok) begin
                  stop_good = 1'b1;
               end else begin
                  stop_bad = 1'b1;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end else if (state != ST_IDLE && to_cnt == TO_LAST) begin
         state_nxt   = ST_IDLE;
         timeout_hit = 1'b1;
      end
   end

   // Bit capture, timeout counting and hand-off of a completed byte to the decoder.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         to_cnt     <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         byte_valid <= 1'b0;
         byte_reg   <= '0;
         frame_err  <= 1'b0;
      end else begin
         if (fall_stb || state == ST_IDLE || timeout_hit) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
         if (fall_stb) begin
            case (state)
               ST_IDLE: begin
                  bit_cnt <= '0;
               end
               ST_DATA: begin
                  shift_reg <= {data_sync, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 1'b1;
               end
               ST_PARITY: begin
                  parity_bit <= data_sync;
               end
               default: begin
               end
            endcase
         end
         byte_valid <= stop_good;
         if (stop_good) begin
            byte_reg <= shift_reg;
         end
         frame_err <= stop_bad | timeout_hit;
      end
   end

   // Classify the received byte: protocol replies are dropped unless a prefix is pending; repeats may be suppressed.
   always_comb begin
      is_ignored = 1'b0;
      emit_ok    = 1'b1;
      if (!ext_flag && !brk_flag) begin
         case (byte_reg)
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: is_ignored = 1'b1;
            default: is_ignored = 1'b0;
         endcase
      end
`ifdef PS2_REPEAT_FILTER_EN
      rep_match = rep_valid && (rep_key == {ext_flag, byte_reg});
      if (!brk_flag && rep_match) begin
         emit_ok = 1'b0;
      end
`endif
   end

   // Prefix tracking and event emission; any frame error flushes the pending prefixes.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         ps2_key   <= '0;
         ext_flag  <= 1'b0;
         brk_flag  <= 1'b0;
         skip_cnt  <= '0;
`ifdef PS2_REPEAT_FILTER_EN
         rep_valid <= 1'b0;
         rep_key   <= '0;
`endif
      end else if (stop_bad || timeout_hit) begin
         ext_flag  <= 1'b0;
         brk_flag  <= 1'b0;
         skip_cnt  <= '0;
`ifdef PS2_REPEAT_FILTER_EN
         rep_valid <= 1'b0;
`endif
      end else if (byte_valid) begin
         if (skip_cnt != 3'd0) begin
            skip_cnt <= skip_cnt - 1'b1;
         end else if (byte_reg == 8'hE0) begin
            ext_flag <= 1'b1;
         end else if (byte_reg == 8'hF0) begin
            brk_flag <= 1'b1;
         end else if (byte_reg == 8'hE1) begin
            skip_cnt <= 3'd7;
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
         end else if (!is_ignored) begin
            if (emit_ok) begin
               ps2_key <= {~ps2_key[10], ~brk_flag, ext_flag, byte_reg};
            end
`ifdef PS2_REPEAT_FILTER_EN
            if (!brk_flag) begin
               rep_key   <= {ext_flag, byte_reg};
               rep_valid <= 1'b1;
            end else if (rep_match) begin
               rep_valid <= 1'b0;
            end
`endif
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Self-checking bench for ps2_key_rx: directed scenarios plus random byte
// streams compared against a behavioural model of the key event rules.
// Honours PS2_REPEAT_FILTER_EN in the model when the build defines it.
module tb_ps2_key_rx;

   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 300;
   localparam int HALF       = 20;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ps2_clk_in;
   logic        ps2_data_in;
   logic [10:0] ps2_key;
   logic        frame_err;

   int total = 0;
   int bad   = 0;

   int   tog_cnt  = 0;
   int   err_cnt  = 0;
   int   err_wide = 0;
   logic prev_tog = 1'b0;
   logic prev_err = 1'b0;

   logic [10:0] exp_key;
   int          exp_events;
   int          exp_errs;
   bit          m_ext;
   bit          m_brk;
   int          m_skip;
   bit          m_rep_valid;
   logic [8:0]  m_rep_key;

   ps2_key_rx #(
      .FILTER_LEN(FILTER_LEN),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_key    (ps2_key),
      .frame_err  (frame_err)
   );

   // Free-running system clock.
   always #5 clk_sys = ~clk_sys;

   // Count toggles of the event bit and frame_err pulses, flagging pulses wider than one cycle.
   always @(negedge clk_sys) begin
      if (reset) begin
         tog_cnt  <= 0;
         err_cnt  <= 0;
         err_wide <= 0;
         prev_tog <= 1'b0;
         prev_err <= 1'b0;
      end else begin
         if (ps2_key[10] !== prev_tog) tog_cnt <= tog_cnt + 1;
         if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
         if (frame_err === 1'b1 && prev_err === 1'b1) err_wide <= err_wide + 1;
         prev_tog <= ps2_key[10];
         prev_err <= frame_err;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic model_reset();
      exp_key     = '0;
      exp_events  = 0;
      exp_errs    = 0;
      m_ext       = 0;
      m_brk       = 0;
      m_skip      = 0;
      m_rep_valid = 0;
      m_rep_key   = '0;
   endtask

   task automatic model_error();
      exp_errs++;
      m_ext       = 0;
      m_brk       = 0;
      m_skip      = 0;
      m_rep_valid = 0;
   endtask

   task automatic model_byte(input logic [7:0] b, input bit good);
      bit make;
      bit suppress;
      if (!good) begin
         model_error();
      end else if (m_skip > 0) begin
         m_skip--;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else if (b == 8'hE1) begin
         m_skip = 7;
         m_ext  = 0;
         m_brk  = 0;
      end else if (!m_ext && !m_brk && (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
      end else begin
         make     = !m_brk;
         suppress = 0;
`ifdef PS2_REPEAT_FILTER_EN
         if (make) begin
            if (m_rep_valid && m_rep_key == {m_ext, b}) suppress = 1;
            m_rep_key   = {m_ext, b};
            m_rep_valid = 1;
         end else if (m_rep_valid && m_rep_key == {m_ext, b}) begin
            m_rep_valid = 0;
         end
`endif
         if (!suppress) begin
            exp_key = {~exp_key[10], make, m_ext, b};
            exp_events++;
         end
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   task automatic drive_bit(input logic v);
      ps2_data_in = v;
      repeat (HALF) @(negedge clk_sys);
      ps2_clk_in = 1'b0;
      repeat (HALF) @(negedge clk_sys);
      ps2_clk_in = 1'b1;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit check_lat);
      logic [10:0] bits;
      logic [10:0] key_before;
      logic        par;
      par = ~(^b);
      if (bad_par) par = ~par;
      bits       = {1'b1, par, b, 1'b0};
      key_before = exp_key;
      model_byte(b, !bad_par);
      for (int i = 0; i < 10; i++) drive_bit(bits[i]);
      ps2_data_in = bits[10];
      repeat (HALF) @(negedge clk_sys);
      ps2_clk_in = 1'b0;
      if (check_lat) begin
         repeat (FILTER_LEN + 3) @(posedge clk_sys);
         #1 checkOutput("latency_before", 32'(ps2_key), 32'(key_before));
         @(posedge clk_sys);
         #1 checkOutput("latency_at", 32'(ps2_key), 32'(exp_key));
      end
      repeat (HALF) @(negedge clk_sys);
      ps2_clk_in = 1'b1;
      repeat (20) @(negedge clk_sys);
   endtask

   task automatic check_state(input string tag);
      checkOutput({tag, "_key"}, 32'(ps2_key), 32'(exp_key));
      checkOutput({tag, "_toggles"}, tog_cnt, exp_events);
      checkOutput({tag, "_errs"}, err_cnt, exp_errs);
      checkOutput({tag, "_errwidth"}, err_wide, 0);
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      ps2_clk_in  = 1'b1;
      ps2_data_in = 1'b1;
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      model_reset();
      repeat (5) @(negedge clk_sys);
   endtask

   logic [7:0] seq_e1 [8];
   logic [7:0] seq_rep [6];
   logic [7:0] key_pool [4];
   int         tog_base;
   int         exp_delta;
   logic [7:0] rb;
   int         sel;

   initial begin
      reset       = 1'b1;
      ps2_clk_in  = 1'b1;
      ps2_data_in = 1'b1;
      seq_e1   = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      seq_rep  = '{8'h6B, 8'h6B, 8'h6B, 8'hF0, 8'h6B, 8'h6B};
      key_pool = '{8'h1C, 8'h6B, 8'h29, 8'h75};

      do_reset();
      checkOutput("reset_key", 32'(ps2_key), 32'h0);
      checkOutput("reset_err", 32'(frame_err), 32'h0);

      applyStimulus(8'h1C, 0, 1);
      checkOutput("make_1c", 32'(ps2_key), 32'({1'b1, 1'b1, 1'b0, 8'h1C}));
      check_state("f1c");

      applyStimulus(8'hE0, 0, 0);
      applyStimulus(8'hF0, 0, 0);
      applyStimulus(8'h75, 0, 0);
      checkOutput("ext_break_75", 32'(ps2_key), 32'({1'b0, 1'b0, 1'b1, 8'h75}));
      check_state("e0f075");

      applyStimulus(8'h29, 1, 0);
      check_state("badpar");
      applyStimulus(8'h29, 0, 0);
      checkOutput("make_29", 32'(ps2_key[9:0]), 32'({1'b1, 1'b0, 8'h29}));
      check_state("good29");

      ps2_data_in = 1'b0;
      ps2_clk_in  = 1'b0;
      repeat (FILTER_LEN - 1) @(negedge clk_sys);
      ps2_clk_in  = 1'b1;
      repeat (10) @(negedge clk_sys);
      ps2_data_in = 1'b1;
      repeat (10) @(negedge clk_sys);
      check_state("glitch");

      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(i[0]);
      repeat (TIMEOUT + FILTER_LEN + 40) @(negedge clk_sys);
      model_error();
      check_state("timeout");
      applyStimulus(8'h16, 0, 1);
      checkOutput("make_16", 32'(ps2_key[9:0]), 32'({1'b1, 1'b0, 8'h16}));
      check_state("after_to");

      for (int i = 0; i < 8; i++) applyStimulus(seq_e1[i], 0, 0);
      check_state("pause_seq");
      applyStimulus(8'h05, 0, 0);
      checkOutput("make_05", 32'(ps2_key[9:0]), 32'({1'b1, 1'b0, 8'h05}));
      check_state("after_pause");

      tog_base = tog_cnt;
      for (int i = 0; i < 6; i++) applyStimulus(seq_rep[i], 0, 0);
`ifdef PS2_REPEAT_FILTER_EN
      exp_delta = 3;
`else
      exp_delta = 5;
`endif
      checkOutput("repeat_toggles", tog_cnt - tog_base, exp_delta);
      check_state("repeat");

      for (int n = 0; n < 40; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel == 0) rb = 8'hE0;
         else if (sel == 1) rb = 8'hF0;
         else if (sel == 2 && $urandom_range(0, 3) == 0) rb = 8'hE1;
         else if (sel <= 6) rb = key_pool[$urandom_range(0, 3)];
         else rb = 8'($urandom);
         applyStimulus(rb, $urandom_range(0, 7) == 0, n < 3);
         check_state("rand");
      end

      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      do_reset();
      check_state("midreset");
      applyStimulus(8'h1C, 0, 0);
      checkOutput("post_reset_1c", 32'(ps2_key), 32'({1'b1, 1'b1, 1'b0, 8'h1C}));
      check_state("post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
